// File: rtl/la_ioring_pkg.sv
// la_ioring_pkg
//   Shared definitions for the pad-ring configuration path: the sequencer
//   state encoding and the bit positions of the ioring scan bus.
package la_ioring_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } ioring_state_t;

    // ioring bus bit positions; bits above SLATCH are reserved and driven 0
    localparam int SCLK   = 0;
    localparam int SDATA  = 1;
    localparam int SLATCH = 2;

endpackage

// File: rtl/la_ioring_clkdiv.sv
// la_ioring_clkdiv
//   Loadable down-counter that paces the scan clock phases. Raises tick for
//   one cycle every (period+1) cycles while enabled; load restarts the count
//   so that every phase starts with a full period.
// Ports
//   clk, reset  core clock, asynchronous active-high reset
//   en          count enable (phase in progress)
//   load        restart the count from period
//   period      phase length minus 1, in clk cycles
//   tick        last cycle of the current phase
module la_ioring_clkdiv #(
    parameter int DIVW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            load,
    input  logic [DIVW-1:0] period,
    output logic            tick
);

    logic [DIVW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= period;
        end else if (en) begin
            cnt <= (cnt == '0) ? period : cnt - DIVW'(1);
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/la_ioring_cfg.sv
// la_ioring_cfg
//   Pad-ring configuration sequencer. Holds one config word per pad and, on
//   start, shifts the whole ring image out on the ioring scan bus (pad N-1
//   MSB first, pad 0 LSB last), then pulses slatch so the io cells commit.
// Ports
//   clk, reset        core clock, asynchronous active-high reset
//   cfg_valid/ready   config write handshake; cfg_addr selects the pad,
//                     cfg_data is the word; out-of-range addresses are dropped
//   start             commit request, honoured only in IDLE
//   div               scan clock half-period minus 1, sampled at start
//   busy              shift/latch sequence in progress
//   done              one-cycle pulse at the end of the sequence
//   ioring            [0]=sclk [1]=sdata [2]=slatch, upper bits 0
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting; writes accepted, start snapshots the array
// SHIFT_LO | sclk low, sdata presents the current bit
// SHIFT_HI | sclk high, sdata held; chain samples on the rising edge
// LATCH    | slatch high, sclk/sdata low, for one phase
// DONE     | done pulse, back to IDLE
module la_ioring_cfg
    import la_ioring_pkg::*;
#(
    parameter int N     = 16,
    parameter int CFGW  = 8,
    parameter int RINGW = 8,
    parameter int DIVW  = 8,
    parameter int AW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [CFGW-1:0]  cfg_data,
    input  logic             start,
    input  logic [DIVW-1:0]  div,
    output logic             busy,
    output logic             done,
    output logic [RINGW-1:0] ioring
);

    localparam int NB  = N * CFGW;
    localparam int BCW = $clog2(NB + 1);

    ioring_state_t             state;
    logic [N-1:0][CFGW-1:0]    arr;
    logic [NB-1:0]             arr_flat;
    logic [NB-1:0]             shreg;
    logic [NB-1:0]             shreg_next;
    logic [BCW-1:0]            bit_cnt;
    logic [DIVW-1:0]           div_q;
    logic [DIVW-1:0]           period;
    logic                      div_en;
    logic                      div_load;
    logic                      tick;
    logic                      sclk_q;
    logic                      sdata_q;
    logic                      slatch_q;
    logic                      busy_q;
    logic                      done_q;

    // pad N-1 occupies the top word, so the image's MSB leaves first
    assign arr_flat   = arr;
    assign shreg_next = shreg << 1;

    assign cfg_ready = (state == IDLE) && !start;

    // Match the address against each pad rather than indexing, so addresses
    // beyond the last pad simply hit nothing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arr <= '0;
        end else if (cfg_valid && cfg_ready) begin
            for (int i = 0; i < N; i++) begin
                if (32'(cfg_addr) == i) begin
                    arr[i] <= cfg_data;
                end
            end
        end
    end

    // div_q is not yet valid in the start cycle, so the first phase loads div
    assign period   = (state == IDLE) ? div : div_q;
    assign div_en   = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == LATCH);
    assign div_load = ((state == IDLE) && start) ||
                      (tick && ((state == SHIFT_LO) || (state == SHIFT_HI)));

    la_ioring_clkdiv #(
        .DIVW (DIVW)
    ) u_clkdiv (
        .clk    (clk),
        .reset  (reset),
        .en     (div_en),
        .load   (div_load),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            div_q    <= '0;
            sclk_q   <= 1'b0;
            sdata_q  <= 1'b0;
            slatch_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SHIFT_LO;
                        shreg   <= arr_flat;
                        sdata_q <= arr_flat[NB-1];
                        bit_cnt <= BCW'(NB);
                        div_q   <= div;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT_LO: begin
                    if (tick) begin
                        state  <= SHIFT_HI;
                        sclk_q <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (tick) begin
                        sclk_q  <= 1'b0;
                        bit_cnt <= bit_cnt - BCW'(1);
                        if (bit_cnt == BCW'(1)) begin
                            state    <= LATCH;
                            sdata_q  <= 1'b0;
                            slatch_q <= 1'b1;
                        end else begin
                            state   <= SHIFT_LO;
                            shreg   <= shreg_next;
                            sdata_q <= shreg_next[NB-1];
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        state    <= DONE;
                        slatch_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ioring         = '0;
        ioring[SCLK]   = sclk_q;
        ioring[SDATA]  = sdata_q;
        ioring[SLATCH] = slatch_q;
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_la_ioring_cfg.sv
// tb_la_ioring_cfg
//   Bench for la_ioring_cfg with a 4-pad, 4-bit ring. A behavioural model
//   tracks the pad array and the time since start; every cycle the expected
//   bus is derived arithmetically from that time (phase = elapsed / T) and
//   compared with the DUT. Directed runs also check literal lengths/images.
module tb_la_ioring_cfg;

    localparam int N     = 4;
    localparam int CFGW  = 4;
    localparam int RINGW = 8;
    localparam int DIVW  = 8;
    localparam int AW    = 3;
    localparam int NB    = N * CFGW;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [AW-1:0]    cfg_addr;
    logic [CFGW-1:0]  cfg_data;
    logic             start;
    logic [DIVW-1:0]  div;
    logic             busy;
    logic             done;
    logic [RINGW-1:0] ioring;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    la_ioring_cfg #(
        .N     (N),
        .CFGW  (CFGW),
        .RINGW (RINGW),
        .DIVW  (DIVW),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .start     (start),
        .div       (div),
        .busy      (busy),
        .done      (done),
        .ioring    (ioring)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: k = 0 when idle, else cycles since the start edge (k=1 is the
    // first busy cycle). The sequence is (2*NB+1) phases of tm cycles each.
    logic [CFGW-1:0] mem [N];
    int              k;
    int              tm;
    logic [NB-1:0]   snap;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k    <= 0;
            tm   <= 1;
            snap <= '0;
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (k == 0) begin
            if (start) begin
                k    <= 1;
                tm   <= int'(div) + 1;
                snap <= {mem[3], mem[2], mem[1], mem[0]};
            end else if (cfg_valid && int'(cfg_addr) < N) begin
                mem[cfg_addr[1:0]] <= cfg_data;
            end
        end else if (k == (2 * NB + 1) * tm + 1) begin
            k <= 0;
        end else begin
            k <= k + 1;
        end
    end

    int               m_len;
    int               m_ph;
    logic [RINGW-1:0] m_ring;
    logic             m_busy;
    logic             m_done;
    logic             m_ready;

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            m_len  = (2 * NB + 1) * tm;
            m_busy = (k >= 1) && (k <= m_len);
            m_done = (k == m_len + 1);
            m_ring = '0;
            if (m_busy) begin
                m_ph = (k - 1) / tm;
                if (m_ph < 2 * NB) begin
                    m_ring[0] = m_ph[0];
                    m_ring[1] = snap[NB - 1 - m_ph / 2];
                end else begin
                    m_ring[2] = 1'b1;
                end
            end
            m_ready = (k == 0) && !start;
            chk("ioring", ioring, m_ring);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("cfg_ready", cfg_ready, m_ready);
        end
    end

    task automatic wr(input int a, input int d);
        cfg_valid = 1'b1;
        cfg_addr  = AW'(a);
        cfg_data  = CFGW'(d);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    // Runs one commit; returns busy cycle count, cycle of done, the image a
    // chain would capture on sclk rising edges, and slatch-high cycle count.
    task automatic run_seq(input int d, input bit poke, input bit wr_same,
                           output int bc, output int dc,
                           output logic [NB-1:0] ch, output int lc);
        int lim;
        bit prev_sclk;
        bc = 0; dc = -1; ch = '0; lc = 0; prev_sclk = 1'b0;
        lim = (2 * NB + 1) * (d + 1) + 10;
        div = DIVW'(d);
        start = 1'b1;
        if (wr_same) begin
            cfg_valid = 1'b1; cfg_addr = 1; cfg_data = 4'hF;
        end
        @(posedge clk); #1;
        start = 1'b0; cfg_valid = 1'b0;
        for (int c = 1; c <= lim; c++) begin
            @(negedge clk);
            if (busy) bc++;
            if (ioring[2]) lc++;
            if (ioring[0] && !prev_sclk) ch = {ch[NB-2:0], ioring[1]};
            prev_sclk = ioring[0];
            if (done) begin
                dc = c;
                break;
            end
            @(posedge clk); #1;
            if (poke) begin
                start = (c == 5); cfg_valid = (c == 5); cfg_addr = 0; cfg_data = 4'hF;
            end
        end
        start = 1'b0; cfg_valid = 1'b0;
        chk("done_seen", dc > 0, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int bc, dc, lc, d;
        logic [NB-1:0] ch;
        reset = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0; div = '0;
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("rst_ioring", ioring, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        cmp_en = 1'b1;

        wr(0, 1); wr(1, 2); wr(2, 4); wr(3, 8);
        run_seq(0, 0, 0, bc, dc, ch, lc);
        chk("div0_busy_len", bc, 33); chk("div0_done_at", dc, 34);
        chk("div0_chain", ch, 16'h8421); chk("div0_latch", lc, 1);

        run_seq(3, 0, 0, bc, dc, ch, lc);
        chk("div3_busy_len", bc, 132); chk("div3_done_at", dc, 133);
        chk("div3_chain", ch, 16'h8421); chk("div3_latch", lc, 4);

        run_seq(0, 1, 0, bc, dc, ch, lc);
        chk("restart_busy_len", bc, 33); chk("restart_done_at", dc, 34);
        chk("restart_chain", ch, 16'h8421);

        run_seq(0, 0, 1, bc, dc, ch, lc);
        chk("wr_start_chain", ch, 16'h8421); chk("wr_start_busy_len", bc, 33);

        wr(5, 4'hF); wr(4, 4'hF);
        run_seq(1, 0, 0, bc, dc, ch, lc);
        chk("oob_chain", ch, 16'h8421); chk("div1_busy_len", bc, 66);
        chk("div1_done_at", dc, 67); chk("div1_latch", lc, 2);

        for (int it = 0; it < 8; it++) begin
            repeat (6) begin
                cfg_valid = 1'($urandom % 2);
                cfg_addr  = AW'($urandom % 8);
                cfg_data  = CFGW'($urandom);
                @(posedge clk); #1;
            end
            cfg_valid = 1'b0;
            d = int'($urandom % 4);
            run_seq(d, 1'($urandom % 2), 1'($urandom % 2), bc, dc, ch, lc);
            chk("rnd_busy_len", bc, (2 * NB + 1) * (d + 1));
            chk("rnd_done_at", dc, (2 * NB + 1) * (d + 1) + 1);
            chk("rnd_chain", ch, snap);
            chk("rnd_latch", lc, d + 1);
        end

        run_seq(255, 0, 0, bc, dc, ch, lc);
        chk("divmax_busy_len", bc, 8448); chk("divmax_done_at", dc, 8449);
        chk("divmax_chain", ch, snap); chk("divmax_latch", lc, 256);

        wr(0, 4'hA); wr(3, 4'h5);
        div = 1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (28) @(posedge clk);
        #2;
        chk("pre_abort_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_ioring", ioring, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        lc = 0;
        repeat (4) begin
            @(negedge clk);
            if (ioring[2]) lc++;
        end
        chk("abort_no_latch", lc, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_seq(0, 0, 0, bc, dc, ch, lc);
        chk("post_abort_chain", ch, 16'h0000);
        chk("post_abort_busy_len", bc, 33);
        chk("post_abort_latch", lc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
